// File: rtl/piso_tx_if.sv
// -----------------------------------------------------------------------------
// piso_tx_if -- handshake / data bundle for the piso_tx serialiser.
//
// Signals:
//   load      request to accept pi for transmission (master -> slave)
//   pi        parallel word to serialise, WIDTH bits (master -> slave)
//   ready     slave will accept a load on the next rising edge
//   so        serial data bit, MSB first
//   so_valid  so carries a frame bit this cycle
//   done      one-cycle pulse on the last bit of a frame
//
// Modports:
//   master  the word producer (drives load/pi, observes the serial side)
//   slave   the serialiser itself
// -----------------------------------------------------------------------------
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] pi;
    logic             ready;
    logic             so;
    logic             so_valid;
    logic             done;

    modport master (
        output load,
        output pi,
        input  ready,
        input  so,
        input  so_valid,
        input  done
    );

    modport slave (
        input  load,
        input  pi,
        output ready,
        output so,
        output so_valid,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out transmitter.
//
// Accepts a WIDTH-bit word when ready and load are both high, then emits it
// MSB first, one bit per clock, with so_valid high for every frame bit and a
// one-cycle done pulse on the final frame bit. All outputs are registered, so
// the first bit appears in the cycle after the accepting edge.
//
// Optional feature (compile-time macro PISO_TX_PARITY_EN):
//   defined   : the WIDTH data bits are followed by one even-parity bit
//               (XOR of the captured word); done marks the parity bit.
//   undefined : no parity state; done marks data bit pi[0].
//
// Ports:
//   clk    single clock, rising edge
//   clear  synchronous active-high reset, wins over load on the same edge
//   bus    piso_tx_if slave modport (load, pi, ready, so, so_valid, done)
//
// Parameters:
//   WIDTH  parallel word width, legal range 2..32
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     clear,
    piso_tx_if.slave bus
);

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
`ifndef PISO_TX_PARITY_EN
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
`endif

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    // Even parity of a word: XOR of all its bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             so_r;
    logic             so_valid_r;
    logic             done_r;
    logic             ready_r;

    // Next value of the bit counter: decrement, but never wrap below zero.
    logic [CW-1:0]    cnt_dec_s;
    // Shift register rotated by one position (MSB wraps to LSB). Rotating
    // rather than shifting keeps every captured bit in the register, so the
    // parity of the captured word can still be read at the end of the frame.
    logic [WIDTH-1:0] shreg_rot_s;

    // Saturating decrement and rotation helpers for the SHIFT state.
    always_comb begin
        cnt_dec_s   = CNT_ZERO;
        shreg_rot_s = {shreg_r[WIDTH-2:0], shreg_r[WIDTH-1]};
        if (cnt_r != CNT_ZERO) begin
            cnt_dec_s = cnt_r - CNT_ONE;
        end else begin
            cnt_dec_s = CNT_ZERO;
        end
    end

    // Frame sequencer: state, shift register, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {WIDTH{1'b0}};
            cnt_r      <= CNT_ZERO;
            so_r       <= 1'b0;
            so_valid_r <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load) begin
                        // Accept: the MSB is presented straight away so it
                        // appears one cycle after this edge.
                        state_r    <= ST_SHIFT;
                        shreg_r    <= bus.pi;
                        cnt_r      <= CNT_FULL;
                        so_r       <= bus.pi[WIDTH-1];
                        so_valid_r <= 1'b1;
                        done_r     <= 1'b0;
                        ready_r    <= 1'b0;
                    end else begin
                        state_r    <= ST_IDLE;
                        so_r       <= 1'b0;
                        so_valid_r <= 1'b0;
                        done_r     <= 1'b0;
                        ready_r    <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // cnt_r counts the data bits still to be shown including
                    // the one currently on so; load is ignored here.
                    cnt_r   <= cnt_dec_s;
                    shreg_r <= shreg_rot_s;
                    if (cnt_r <= CNT_ONE) begin
                        // Last data bit is on so this cycle.
`ifdef PISO_TX_PARITY_EN
                        state_r    <= ST_PARITY;
                        so_r       <= even_parity(shreg_r);
                        so_valid_r <= 1'b1;
                        done_r     <= 1'b1;
                        ready_r    <= 1'b0;
`else
                        state_r    <= ST_IDLE;
                        so_r       <= 1'b0;
                        so_valid_r <= 1'b0;
                        done_r     <= 1'b0;
                        ready_r    <= 1'b1;
`endif
                    end else begin
                        state_r    <= ST_SHIFT;
                        so_r       <= shreg_r[WIDTH-2];
                        so_valid_r <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                        done_r     <= 1'b0;
`else
                        // Next bit is the last data bit when two remain now.
                        done_r     <= (cnt_r == CNT_TWO);
`endif
                        ready_r    <= 1'b0;
                    end
                end

`ifdef PISO_TX_PARITY_EN
                ST_PARITY: begin
                    state_r    <= ST_IDLE;
                    so_r       <= 1'b0;
                    so_valid_r <= 1'b0;
                    done_r     <= 1'b0;
                    ready_r    <= 1'b1;
                end
`endif

                default: begin
                    state_r    <= ST_IDLE;
                    shreg_r    <= {WIDTH{1'b0}};
                    cnt_r      <= CNT_ZERO;
                    so_r       <= 1'b0;
                    so_valid_r <= 1'b0;
                    done_r     <= 1'b0;
                    ready_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.so       = so_r;
    assign bus.so_valid = so_valid_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx -- directed self-checking bench for piso_tx (WIDTH=4).
// Covers reset state, basic frame, optional parity bit, load while busy,
// clear mid-frame, back-to-back frames with pi changing after capture, and a
// loopback into a 4-bit serial-in/parallel-out register.
// -----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W = 4;

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    piso_tx_if #(.WIDTH(W)) bus ();

    piso_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit SIPO fed by so: shifts in the first four valid bits of a frame.
    logic [3:0] sipo_r;
    int         sipo_cnt_r;
    always_ff @(posedge clk) begin
        if (clear) begin
            sipo_r     <= 4'b0000;
            sipo_cnt_r <= 0;
        end else if (bus.so_valid) begin
            if (sipo_cnt_r < 4) begin
                sipo_r     <= {sipo_r[2:0], bus.so};
                sipo_cnt_r <= sipo_cnt_r + 1;
            end
        end else begin
            sipo_cnt_r <= 0;
        end
    end

    // Advance one clock and settle 1 ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs against expectations.
    task automatic chk(input string tag, input logic e_so, input logic e_v,
                       input logic e_d, input logic e_rdy);
        checks++;
        assert ({bus.so, bus.so_valid, bus.done, bus.ready} === {e_so, e_v, e_d, e_rdy})
        else begin
            errors++;
            $error("FAIL %s: so/valid/done/ready observed %b%b%b%b expected %b%b%b%b",
                   tag, bus.so, bus.so_valid, bus.done, bus.ready,
                   e_so, e_v, e_d, e_rdy);
        end
    endtask

    // Called in the first cycle after the accepting edge; checks a whole
    // frame and returns in the first cycle after the last frame bit.
    task automatic frame(input string tag, input logic [3:0] word, input logic pbit);
        for (int i = 3; i >= 0; i--) begin
`ifdef PISO_TX_PARITY_EN
            chk($sformatf("%s_bit%0d", tag, i), word[i], 1'b1, 1'b0, 1'b0);
`else
            chk($sformatf("%s_bit%0d", tag, i), word[i], 1'b1, (i == 0), 1'b0);
`endif
            step();
        end
`ifdef PISO_TX_PARITY_EN
        chk($sformatf("%s_par", tag), pbit, 1'b1, 1'b1, 1'b0);
        step();
`else
        if (pbit === 1'bx) $error("FAIL %s: parity argument unknown", tag);
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clear     = 1'b1;
        bus.load  = 1'b0;
        bus.pi    = 4'b0000;

        // Reset, with load asserted to show clear wins.
        bus.load = 1'b1;
        bus.pi   = 4'b1111;
        step();
        chk("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b0;
        clear    = 1'b0;
        step();
        chk("idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic frame 1011 (parity 1).
        bus.pi   = 4'b1011;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.pi   = 4'b0000;
        frame("basic", 4'b1011, 1'b1);
        chk("basic_after", 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        assert (sipo_r === 4'b1011)
        else begin
            errors++;
            $error("FAIL loopback: sipo observed %b expected %b", sipo_r, 4'b1011);
        end
        step();

        // Parity 0 case: 0110.
        bus.pi   = 4'b0110;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        frame("w0110", 4'b0110, 1'b0);
        chk("w0110_after", 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // Load while busy: 1100, then load 0011 during the second bit.
        bus.pi   = 4'b1100;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("busy_b3", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.pi   = 4'b0011;
        bus.load = 1'b1;
        chk("busy_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.load = 1'b0;
        chk("busy_b1", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
`ifdef PISO_TX_PARITY_EN
        chk("busy_b0", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("busy_par", 1'b0, 1'b1, 1'b1, 1'b0);
`else
        chk("busy_b0", 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        step();
        chk("busy_after", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("busy_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear mid-frame: 1111, clear on the edge ending the second bit.
        bus.pi   = 4'b1111;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("abort_b3", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("abort_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("abort_clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort_quiet%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Back-to-back with load held: 1001 then 0110, pi changed after capture.
        bus.pi   = 4'b1001;
        bus.load = 1'b1;
        step();
        bus.pi   = 4'b0110;
        frame("b2b_a", 4'b1001, 1'b0);
        chk("b2b_gap", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        bus.load = 1'b0;
        bus.pi   = 4'b1111;
        frame("b2b_b", 4'b0110, 1'b0);
        chk("b2b_after", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
